single_port_sram_param: RTL and testbench
=========================================

SINGLE_PORT_SRAM_PARAM -- requirements
Module: single_port_sram_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; depth SHALL be DEPTH = 2**ADDR_WIDTH words.
REQ-003 Clk_In  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Reset_In  input  1: asynchronous, active-low reset.
REQ-005 Data_In  input  DATA_WIDTH: write data.
REQ-006 Address_In  input  ADDR_WIDTH: word address for read and write.
REQ-007 Byte_Enable_In  input  DATA_WIDTH/8: per-byte write mask; bit i covers Data_In[8i+7:8i].
REQ-008 Write_Enable  input  1: write request, sampled each cycle.
REQ-009 Read_Enable  input  1: read request, sampled each cycle.
REQ-010 Clear_In  input  1: single-cycle request to zero the whole array.
REQ-011 Data_Out  output  DATA_WIDTH: registered read data.
REQ-012 Data_Valid_Out  output  1: one-cycle pulse qualifying Data_Out.
REQ-013 Busy_Out  output  1: high while an init or clear sweep is running; requests are ignored.

Function
REQ-014 FSM states: INIT, READY, CLEAR. Reset SHALL enter INIT; INIT and CLEAR SHALL go to READY after the sweep ends.
REQ-015 Sweep: an ADDR_WIDTH-bit counter SHALL start at 0 and write all-zero words to one address per cycle, ending at DEPTH-1. The sweep SHALL take exactly DEPTH cycles.
REQ-016 Busy_Out SHALL be high in INIT and CLEAR. It SHALL go low on the first cycle in READY.
REQ-017 Write_Enable, Read_Enable and Clear_In SHALL be ignored while Busy_Out is high. No queuing.
REQ-018 In READY, a write SHALL update only the bytes whose Byte_Enable_In bit is 1. Other bytes SHALL be retained. If Byte_Enable_In is all-zero, the write SHALL have no effect.
REQ-019 In READY, a read SHALL load Data_Out with the word at Address_In. Data_Valid_Out SHALL be 1 for exactly the following cycle. Latency is 1 cycle.
REQ-020 Data_Out SHALL hold its last value when no read occurs. Data_Valid_Out SHALL be 0 in that case.
REQ-021 Simultaneous read and write to the same address SHALL be read-first. Data_Out returns the pre-write contents, and the write commits in the same edge.
REQ-022 Clear_In in READY SHALL take priority over any same-cycle read or write. Those requests SHALL be dropped, and the FSM SHALL enter CLEAR on the next edge.
REQ-023 Back-to-back reads on consecutive cycles SHALL each produce a valid pulse. Data_Valid_Out SHALL stay high continuously.

Reset
REQ-024 While Reset_In is 0, outputs SHALL be: Data_Out = 0, Data_Valid_Out = 0, Busy_Out = 1. The FSM SHALL be in INIT and the sweep counter SHALL be 0.
REQ-025 Reset asserted mid-sweep or mid-access SHALL abort the operation. After release, a full DEPTH-cycle INIT SHALL follow.
REQ-026 Array contents need not be reset asynchronously; they are zeroed by the INIT sweep.

Configuration
REQ-027 Macro OUTPUT_REG_EN selects the output pipeline.
- Defined: an extra output register stage SHALL be added. Read latency SHALL be 2 cycles, and Data_Valid_Out SHALL be delayed with the data. The extra stage SHALL reset to 0.
- Undefined: latency SHALL be 1 cycle as in REQ-019.
- In both cases, REQ-021 and REQ-022 behaviour SHALL be unchanged apart from the latency.

Verification
Scenarios use DATA_WIDTH=16, ADDR_WIDTH=8 and macro undefined, unless stated otherwise.
REQ-028 Init: release reset -> Busy_Out high for exactly 256 cycles, then low. A read of 0x3F then returns 0x0000 with a valid pulse 1 cycle later.
REQ-029 Full write and read: write 0xA5C3 to 0x10 with BE=2'b11, then read 0x10 -> Data_Out=0xA5C3 and Data_Valid_Out=1 on the next cycle only.
REQ-030 Byte write: write 0x1234 to 0x20 with BE=11, then 0xABCD with BE=10, then read -> 0xAB34. A write with BE=00 of 0xFFFF leaves 0xAB34.
REQ-031 Read-first: with 0x10 holding 0xA5C3, assert read and write of 0x5555 in the same cycle -> Data_Out=0xA5C3. The next read returns 0x5555.
REQ-032 Clear: pulse Clear_In alongside a write of 0x7777 to 0x05 -> write dropped and Busy_Out high 256 cycles. A write during busy is ignored, and all reads afterwards return 0x0000.
REQ-033 Reset mid-clear and latency: assert reset at sweep count 100 -> outputs match REQ-024, then INIT runs a full 256 cycles. With OUTPUT_REG_EN defined, repeat REQ-029 -> data and valid appear 2 cycles after the read.

Source files
------------

// File: rtl/single_port_sram_param.sv
// Single-port SRAM with byte-enable writes, read-first behaviour, and a zeroing sweep at reset or on clear.
// Optional macro OUTPUT_REG_EN adds a second output register, giving a read latency of 2 cycles.
module single_port_sram_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    Clk_In,
    input  logic                    Reset_In,
    input  logic [DATA_WIDTH-1:0]   Data_In,
    input  logic [ADDR_WIDTH-1:0]   Address_In,
    input  logic [DATA_WIDTH/8-1:0] Byte_Enable_In,
    input  logic                    Write_Enable,
    input  logic                    Read_Enable,
    input  logic                    Clear_In,
    output logic [DATA_WIDTH-1:0]   Data_Out,
    output logic                    Data_Valid_Out,
    output logic                    Busy_Out
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {INIT, READY, CLEAR} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [NBYTES-1:0]       mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // The array port is shared: the sweep owns it outside READY, and Clear_In suppresses user writes.
    always_comb begin
        mem_we    = '0;
        mem_addr  = Address_In;
        mem_wdata = Data_In;
        if (Reset_In) begin
            if (state != READY) begin
                mem_we    = '1;
                mem_addr  = sweep_cnt;
                mem_wdata = '0;
            end else if (Write_Enable && !Clear_In) begin
                mem_we = Byte_Enable_In;
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (mem_we[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // The read samples the array before the same-edge write commits, which makes it read-first.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state     <= INIT;
            sweep_cnt <= '0;
            busy      <= 1'b1;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                INIT, CLEAR: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (&sweep_cnt) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (Clear_In) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        sweep_cnt <= '0;
                    end else if (Read_Enable) begin
                        rd_data  <= mem[Address_In];
                        rd_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= INIT;
                    busy      <= 1'b1;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    assign Busy_Out = busy;

`ifdef OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= rd_data;
            out_valid_q <= rd_valid;
        end
    end

    assign Data_Out       = out_data_q;
    assign Data_Valid_Out = out_valid_q;
`else
    assign Data_Out       = rd_data;
    assign Data_Valid_Out = rd_valid;
`endif

endmodule

// File: tb/tb_single_port_sram_param.sv
// Directed self-checking bench for single_port_sram_param (DATA_WIDTH=16, ADDR_WIDTH=8).
module tb_single_port_sram_param;

`ifdef OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        Clk_In = 1'b0;
    logic        Reset_In = 1'b0;
    logic [15:0] Data_In = '0;
    logic [7:0]  Address_In = '0;
    logic [1:0]  Byte_Enable_In = '0;
    logic        Write_Enable = 1'b0;
    logic        Read_Enable = 1'b0;
    logic        Clear_In = 1'b0;
    logic [15:0] Data_Out;
    logic        Data_Valid_Out;
    logic        Busy_Out;

    int n_checks = 0;
    int n_fail   = 0;

    single_port_sram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .Clk_In         (Clk_In),
        .Reset_In       (Reset_In),
        .Data_In        (Data_In),
        .Address_In     (Address_In),
        .Byte_Enable_In (Byte_Enable_In),
        .Write_Enable   (Write_Enable),
        .Read_Enable    (Read_Enable),
        .Clear_In       (Clear_In),
        .Data_Out       (Data_Out),
        .Data_Valid_Out (Data_Valid_Out),
        .Busy_Out       (Busy_Out)
    );

    always #5 Clk_In = ~Clk_In;

    task automatic tick;
        @(posedge Clk_In);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        Address_In     = a;
        Data_In        = d;
        Byte_Enable_In = be;
        Write_Enable   = 1'b1;
        tick();
        Write_Enable   = 1'b0;
        Byte_Enable_In = 2'b00;
    endtask

    task automatic do_read(input logic [7:0] a);
        Address_In  = a;
        Read_Enable = 1'b1;
        tick();
        Read_Enable = 1'b0;
`ifdef OUTPUT_REG_EN
        tick();
`endif
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (Busy_Out && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        repeat (3) tick();
        n_checks++;
        if (Data_Out !== 16'h0000 || Data_Valid_Out !== 1'b0 || Busy_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: data=%h valid=%b busy=%b, required data=0000 valid=0 busy=1",
                     Data_Out, Data_Valid_Out, Busy_Out);
        end
        Reset_In = 1'b1;
        wait_busy_low(n);
        n_checks++;
        if (n !== 256) begin
            n_fail++;
            $display("[TB] FAIL init_busy_cycles: got %0d, required 256", n);
        end
        do_read(8'h3F);
        n_checks++;
        if (Data_Out !== 16'h0000 || Data_Valid_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL init_read_3f: data=%h valid=%b, required 0000/1", Data_Out, Data_Valid_Out);
        end
        tick();
        n_checks++;
        if (Data_Valid_Out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL init_valid_pulse: valid=%b, required 0", Data_Valid_Out);
        end
    endtask

    task automatic test_full_write;
        do_write(8'h10, 16'hA5C3, 2'b11);
        do_read(8'h10);
        n_checks++;
        if (Data_Out !== 16'hA5C3 || Data_Valid_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_write_read: data=%h valid=%b, required a5c3/1", Data_Out, Data_Valid_Out);
        end
        tick();
        n_checks++;
        if (Data_Out !== 16'hA5C3 || Data_Valid_Out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_write_hold: data=%h valid=%b, required a5c3/0", Data_Out, Data_Valid_Out);
        end
    endtask

    task automatic test_byte_write;
        do_write(8'h20, 16'h1234, 2'b11);
        do_write(8'h20, 16'hABCD, 2'b10);
        do_read(8'h20);
        n_checks++;
        if (Data_Out !== 16'hAB34 || Data_Valid_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL byte_write_upper: data=%h valid=%b, required ab34/1", Data_Out, Data_Valid_Out);
        end
        do_write(8'h20, 16'hFFFF, 2'b00);
        do_read(8'h20);
        n_checks++;
        if (Data_Out !== 16'hAB34) begin
            n_fail++;
            $display("[TB] FAIL byte_write_none: data=%h, required ab34", Data_Out);
        end
        do_write(8'h20, 16'h00EE, 2'b01);
        do_read(8'h20);
        n_checks++;
        if (Data_Out !== 16'hABEE) begin
            n_fail++;
            $display("[TB] FAIL byte_write_lower: data=%h, required abee", Data_Out);
        end
    endtask

    task automatic test_read_first;
        Address_In     = 8'h10;
        Data_In        = 16'h5555;
        Byte_Enable_In = 2'b11;
        Write_Enable   = 1'b1;
        Read_Enable    = 1'b1;
        tick();
        Write_Enable   = 1'b0;
        Read_Enable    = 1'b0;
        Byte_Enable_In = 2'b00;
`ifdef OUTPUT_REG_EN
        tick();
`endif
        n_checks++;
        if (Data_Out !== 16'hA5C3 || Data_Valid_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL read_first_old: data=%h valid=%b, required a5c3/1", Data_Out, Data_Valid_Out);
        end
        do_read(8'h10);
        n_checks++;
        if (Data_Out !== 16'h5555) begin
            n_fail++;
            $display("[TB] FAIL read_first_new: data=%h, required 5555", Data_Out);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] expv [3];
        expv[0] = 16'h1111;
        expv[1] = 16'h2222;
        expv[2] = 16'h3333;
        for (int i = 0; i < 3; i++) do_write(8'h40 + 8'(i), expv[i], 2'b11);
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            if (k < 3) begin
                Read_Enable = 1'b1;
                Address_In  = 8'h40 + 8'(k);
            end else begin
                Read_Enable = 1'b0;
            end
            tick();
            if (k >= LAT - 1) begin
                n_checks++;
                if (Data_Out !== expv[k-LAT+1] || Data_Valid_Out !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back[%0d]: data=%h valid=%b, required %h/1",
                             k - LAT + 1, Data_Out, Data_Valid_Out, expv[k-LAT+1]);
                end
            end
        end
        Read_Enable = 1'b0;
        tick();
        n_checks++;
        if (Data_Valid_Out !== 1'b0 || Data_Out !== 16'h3333) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_end: data=%h valid=%b, required 3333/0", Data_Out, Data_Valid_Out);
        end
    endtask

    task automatic test_clear;
        int n;
        Clear_In       = 1'b1;
        Write_Enable   = 1'b1;
        Read_Enable    = 1'b1;
        Address_In     = 8'h05;
        Data_In        = 16'h7777;
        Byte_Enable_In = 2'b11;
        tick();
        Clear_In       = 1'b0;
        n_checks++;
        if (Busy_Out !== 1'b1 || Data_Valid_Out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_start: busy=%b valid=%b, required 1/0", Busy_Out, Data_Valid_Out);
        end
        Address_In = 8'h06;
        Data_In    = 16'h1111;
        tick();
        Write_Enable   = 1'b0;
        Read_Enable    = 1'b0;
        Byte_Enable_In = 2'b00;
        n_checks++;
        if (Data_Valid_Out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_busy_read: valid=%b, required 0", Data_Valid_Out);
        end
        wait_busy_low(n);
        n_checks++;
        if (n + 1 !== 256) begin
            n_fail++;
            $display("[TB] FAIL clear_busy_cycles: got %0d, required 256", n + 1);
        end
        do_read(8'h05);
        n_checks++;
        if (Data_Out !== 16'h0000 || Data_Valid_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_addr05: data=%h valid=%b, required 0000/1", Data_Out, Data_Valid_Out);
        end
        do_read(8'h06);
        n_checks++;
        if (Data_Out !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL clear_addr06: data=%h, required 0000", Data_Out);
        end
        do_read(8'h10);
        n_checks++;
        if (Data_Out !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL clear_addr10: data=%h, required 0000", Data_Out);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        do_write(8'h30, 16'hBEEF, 2'b11);
        do_read(8'h30);
        Clear_In = 1'b1;
        tick();
        Clear_In = 1'b0;
        repeat (100) tick();
        n_checks++;
        if (Busy_Out !== 1'b1 || Data_Out !== 16'hBEEF) begin
            n_fail++;
            $display("[TB] FAIL mid_clear_hold: busy=%b data=%h, required 1/beef", Busy_Out, Data_Out);
        end
        Reset_In = 1'b0;
        #1;
        n_checks++;
        if (Data_Out !== 16'h0000 || Data_Valid_Out !== 1'b0 || Busy_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_clear_reset: data=%h valid=%b busy=%b, required 0000/0/1",
                     Data_Out, Data_Valid_Out, Busy_Out);
        end
        repeat (2) tick();
        Reset_In = 1'b1;
        wait_busy_low(n);
        n_checks++;
        if (n !== 256) begin
            n_fail++;
            $display("[TB] FAIL reinit_busy_cycles: got %0d, required 256", n);
        end
        do_read(8'h30);
        n_checks++;
        if (Data_Out !== 16'h0000 || Data_Valid_Out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reinit_addr30: data=%h valid=%b, required 0000/1", Data_Out, Data_Valid_Out);
        end
    endtask

    task automatic test_latency;
        do_write(8'h10, 16'hA5C3, 2'b11);
        Address_In  = 8'h10;
        Read_Enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            Read_Enable = 1'b0;
            n_checks++;
            if (Data_Valid_Out !== (k == LAT)) begin
                n_fail++;
                $display("[TB] FAIL latency_valid[%0d]: valid=%b, required %b", k, Data_Valid_Out, k == LAT);
            end
        end
        n_checks++;
        if (Data_Out !== 16'hA5C3) begin
            n_fail++;
            $display("[TB] FAIL latency_data: data=%h, required a5c3", Data_Out);
        end
    endtask

    initial begin
        $display("[TB] start, read latency %0d", LAT);
        test_reset();
        test_full_write();
        test_byte_write();
        test_read_first();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
